// File: rtl/fsm_checker_pkg.sv
// Shared types, constants and the reference ring-FSM step function for fsm_checker.
package fsm_checker_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} ctl_state_t;

  localparam int DEF_NUM_STATES = 9;
  localparam int STATE_W        = 4;
  localparam int MASK_W         = 9;

  // Next state of the ring FSM: advance (with wrap) only when enabled and the
  // condition bit of the current state is set.
  function automatic logic [STATE_W-1:0] ring_next(
    input logic [STATE_W-1:0] cur,
    input logic               en,
    input logic [MASK_W-1:0]  mask,
    input int unsigned        n = DEF_NUM_STATES
  );
    logic [STATE_W-1:0] nxt;
    nxt = cur;
    if (en && (cur < STATE_W'(n)) && mask[cur]) begin
      nxt = (cur == STATE_W'(n - 1)) ? '0 : cur + 1'b1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/fsm_checker_if.sv
// Link between the checker and the ring FSM under test: condition vector, enable, state.
interface fsm_checker_if;
  import fsm_checker_pkg::*;

  logic [STATE_W-1:0] y;
  logic [MASK_W-1:0]  i;
  logic               en;

  modport master (input y, output i, output en);
  modport slave  (output y, input i, input en);
endinterface

// File: rtl/fsm_checker_lfsr.sv
// 9-bit Fibonacci LFSR (taps 9,5) with synchronous load and step controls.
module fsm_checker_lfsr #(
  parameter logic [8:0] SEED = 9'h1A5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       step,
  output logic [8:0] q
);

  logic [8:0] q_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_reg <= SEED;
    end else if (load) begin
      q_reg <= SEED;
    end else if (step) begin
      q_reg <= {q_reg[7:0], q_reg[8] ^ q_reg[4]};
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/fsm_checker.sv
// Lockstep stimulus/response checker for the 9-state ring FSM.
// Optional LFSR condition mask is enabled with `define FSM_CHECKER_LFSR_EN.
module fsm_checker
  import fsm_checker_pkg::*;
#(
  parameter int NUM_STATES = DEF_NUM_STATES,
  parameter int NUM_CYCLES = 20,
  parameter int CW         = 8
`ifdef FSM_CHECKER_LFSR_EN
  ,
  parameter logic [8:0] LFSR_SEED = 9'h1A5
`endif
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          go,
  fsm_checker_if.master dut,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] err_count,
  output logic [CW-1:0] first_err,
  output logic [CW-1:0] cycle
);

  ctl_state_t         state_reg, state_next;
  logic [STATE_W-1:0] exp_reg;
  logic [CW-1:0]      cycle_reg, err_reg, first_reg;
  logic [MASK_W-1:0]  mask;
  logic [MASK_W-1:0]  i_int;
  logic               en_int;
  logic               start;
  logic               mismatch;

`ifdef FSM_CHECKER_LFSR_EN
  fsm_checker_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .load  (start),
    .step  (state_reg == RUN),
    .q     (mask)
  );
`else
  assign mask = '1;
`endif

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    en_int     = 1'b0;
    i_int      = '0;
    case (state_reg)
      IDLE: begin
        if (go) begin
          state_next = RUN;
          start      = 1'b1;
        end
      end
      RUN: begin
        busy   = 1'b1;
        en_int = 1'b1;
        i_int  = mask;
        if (cycle_reg == CW'(NUM_CYCLES - 1)) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (go) begin
          state_next = RUN;
          start      = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Out-of-range codes never equal exp_reg, but are flagged explicitly for clarity.
  assign mismatch = (dut.y >= STATE_W'(NUM_STATES)) || (dut.y != exp_reg);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      exp_reg   <= '0;
      cycle_reg <= '0;
      err_reg   <= '0;
      first_reg <= '1;
    end else begin
      state_reg <= state_next;
      if (start) begin
        exp_reg   <= '0;
        cycle_reg <= '0;
        err_reg   <= '0;
        first_reg <= '1;
      end else if (state_reg == RUN) begin
        if (mismatch) begin
          if (err_reg != '1) err_reg <= err_reg + 1'b1;
          if (first_reg == '1) first_reg <= cycle_reg;
        end
        exp_reg   <= ring_next(exp_reg, en_int, mask, NUM_STATES);
        cycle_reg <= cycle_reg + 1'b1;
      end
    end
  end

  assign dut.en    = en_int;
  assign dut.i     = i_int;
  assign pass      = done && (err_reg == '0);
  assign err_count = err_reg;
  assign first_err = first_reg;
  assign cycle     = cycle_reg;

endmodule

// File: tb/tb_fsm_checker.sv
// Directed bench for fsm_checker: golden ring FSM plus faulty stubs drive y.
module tb_fsm_checker;
  import fsm_checker_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       go = 1'b0;
  logic       busy, done, pass;
  logic [7:0] err_count, first_err, cycle;

  always #5 clock = ~clock;

  fsm_checker_if dif();

  fsm_checker #(.NUM_CYCLES(20)) u_dut (
    .clock     (clock),
    .reset     (reset),
    .go        (go),
    .dut       (dif.master),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .first_err (first_err),
    .cycle     (cycle)
  );

  // Golden ring FSM; dut_sync realigns it to state 0 without touching the checker.
  logic [3:0] gold_y;
  logic       dut_sync = 1'b0;
  logic       stuck;
  int         mode = 0;  // 0 golden, 1 stuck at 3 from run cycle 3, 2 constant 9

  always @(posedge clock or posedge reset or posedge dut_sync) begin
    if (reset || dut_sync) gold_y <= 4'd0;
    else if (dif.en && dif.i[gold_y]) gold_y <= (gold_y == 4'd8) ? 4'd0 : gold_y + 4'd1;
  end

  always @(posedge clock or posedge reset) begin
    if (reset) stuck <= 1'b0;
    else if (dif.en && gold_y == 4'd3) stuck <= 1'b1;
  end

  assign dif.y = (mode == 1) ? (stuck ? 4'd3 : gold_y) :
                 (mode == 2) ? 4'd9 : gold_y;

  int checks = 0;
  int failures = 0;

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    go    = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Leaves the caller at the falling edge inside run cycle 0.
  task automatic start_run();
    @(negedge clock);
    go = 1'b1;
    @(negedge clock);
    go = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({busy, done, pass, dif.en} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b want=0000", {busy, done, pass, dif.en});
    end
    checks++;
    if (dif.i !== 9'h000) begin
      failures++;
      $display("FAIL reset_i got=%h want=000", dif.i);
    end
    checks++;
    if ({err_count, first_err, cycle} !== {8'h00, 8'hFF, 8'h00}) begin
      failures++;
      $display("FAIL reset_counters got=%h/%h/%h want=00/ff/00", err_count, first_err, cycle);
    end
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({busy, done, dif.en} !== 3'b000) begin
      failures++;
      $display("FAIL idle_hold got=%b want=000", {busy, done, dif.en});
    end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_golden();
    do_reset();
    mode = 0;
    repeat (15) @(negedge clock);
    start_run();
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (!(busy === 1'b1 && dif.en === 1'b1 && dif.i === 9'h1FF && cycle === 8'(c))) begin
        failures++;
        $display("FAIL golden_run c=%0d got busy=%b en=%b i=%h cycle=%0d want 1/1/1ff/%0d",
                 c, busy, dif.en, dif.i, cycle, c);
      end
      @(negedge clock);
    end
    checks++;
    if (!(done === 1'b1 && busy === 1'b0 && pass === 1'b1)) begin
      failures++;
      $display("FAIL golden_done got done=%b busy=%b pass=%b want 1/0/1", done, busy, pass);
    end
    checks++;
    if ({err_count, first_err, dif.en, dif.i} !== {8'h00, 8'hFF, 1'b0, 9'h000}) begin
      failures++;
      $display("FAIL golden_result got err=%h first=%h en=%b i=%h want 00/ff/0/000",
               err_count, first_err, dif.en, dif.i);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (!(done === 1'b1 && pass === 1'b1 && cycle === 8'd20)) begin
      failures++;
      $display("FAIL golden_hold got done=%b pass=%b cycle=%0d want 1/1/20", done, pass, cycle);
    end
    $display("test_golden done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_stuck();
    do_reset();
    mode = 1;
    start_run();
    repeat (7) @(negedge clock);
    checks++;
    if ({err_count, first_err} !== {8'd3, 8'd4}) begin
      failures++;
      $display("FAIL stuck_mid got err=%0d first=%0d want 3/4", err_count, first_err);
    end
    repeat (13) @(negedge clock);
    checks++;
    if ({done, pass, err_count, first_err} !== {1'b1, 1'b0, 8'd15, 8'd4}) begin
      failures++;
      $display("FAIL stuck_done got done=%b pass=%b err=%0d first=%0d want 1/0/15/4",
               done, pass, err_count, first_err);
    end
    $display("test_stuck done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_out_of_range();
    do_reset();
    mode = 2;
    start_run();
    @(negedge clock);
    checks++;
    if ({err_count, first_err} !== {8'd1, 8'd0}) begin
      failures++;
      $display("FAIL oor_first got err=%0d first=%0d want 1/0", err_count, first_err);
    end
    repeat (19) @(negedge clock);
    checks++;
    if ({done, pass, err_count, first_err} !== {1'b1, 1'b0, 8'd20, 8'd0}) begin
      failures++;
      $display("FAIL oor_done got done=%b pass=%b err=%0d first=%0d want 1/0/20/0",
               done, pass, err_count, first_err);
    end
    $display("test_out_of_range done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    mode = 1;
    start_run();
    repeat (7) @(negedge clock);
    checks++;
    if (!(busy === 1'b1 && err_count === 8'd3)) begin
      failures++;
      $display("FAIL midrst_pre got busy=%b err=%0d want 1/3", busy, err_count);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({busy, done, pass, dif.en, dif.i, err_count, first_err, cycle} !==
        {4'b0000, 9'h000, 8'h00, 8'hFF, 8'h00}) begin
      failures++;
      $display("FAIL midrst_values got b=%b d=%b p=%b en=%b i=%h err=%h first=%h cyc=%h",
               busy, done, pass, dif.en, dif.i, err_count, first_err, cycle);
    end
    reset = 1'b0;
    mode  = 0;
    start_run();
    repeat (20) @(negedge clock);
    checks++;
    if ({done, pass, err_count, first_err} !== {1'b1, 1'b1, 8'h00, 8'hFF}) begin
      failures++;
      $display("FAIL midrst_rerun got done=%b pass=%b err=%h first=%h want 1/1/00/ff",
               done, pass, err_count, first_err);
    end
    $display("test_reset_mid_run done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_go_held();
    do_reset();
    mode = 2;
    @(negedge clock);
    go = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      checks++;
      if (!(busy === 1'b1 && cycle === 8'(c))) begin
        failures++;
        $display("FAIL goheld_run c=%0d got busy=%b cycle=%0d want 1/%0d", c, busy, cycle, c);
      end
    end
    @(negedge clock);
    go = 1'b0;
    checks++;
    if ({done, err_count} !== {1'b1, 8'd20}) begin
      failures++;
      $display("FAIL goheld_done got done=%b err=%0d want 1/20", done, err_count);
    end
    // The ring FSM has no clear besides reset; realign it before the second run.
    dut_sync = 1'b1;
    @(negedge clock);
    dut_sync = 1'b0;
    mode     = 0;
    start_run();
    checks++;
    if ({busy, err_count, first_err, cycle} !== {1'b1, 8'h00, 8'hFF, 8'h00}) begin
      failures++;
      $display("FAIL rerun_clear got busy=%b err=%h first=%h cycle=%h want 1/00/ff/00",
               busy, err_count, first_err, cycle);
    end
    repeat (20) @(negedge clock);
    checks++;
    if ({done, pass, err_count, first_err} !== {1'b1, 1'b1, 8'h00, 8'hFF}) begin
      failures++;
      $display("FAIL rerun_done got done=%b pass=%b err=%h first=%h want 1/1/00/ff",
               done, pass, err_count, first_err);
    end
    $display("test_go_held done checks=%0d failures=%0d", checks, failures);
  endtask

`ifdef FSM_CHECKER_LFSR_EN
  task automatic test_lfsr();
    logic [8:0] m;
    logic [8:0] prev;
    int         changes;
    int         holds;
    m       = 9'h1A5;
    prev    = 9'h000;
    changes = 0;
    holds   = 0;
    do_reset();
    mode = 0;
    start_run();
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (dif.i !== m) begin
        failures++;
        $display("FAIL lfsr_mask c=%0d got=%h want=%h", c, dif.i, m);
      end
      if (c > 0 && dif.i !== prev) changes++;
      if (dif.i[gold_y] === 1'b0) holds++;
      prev = dif.i;
      m    = {m[7:0], m[8] ^ m[4]};
      @(negedge clock);
    end
    checks++;
    if ({done, pass, err_count} !== {1'b1, 1'b1, 8'h00}) begin
      failures++;
      $display("FAIL lfsr_done got done=%b pass=%b err=%h want 1/1/00", done, pass, err_count);
    end
    checks++;
    if (changes == 0 || holds == 0) begin
      failures++;
      $display("FAIL lfsr_variety got changes=%0d holds=%0d want both >0", changes, holds);
    end
    $display("test_lfsr done checks=%0d failures=%0d", checks, failures);
  endtask
`endif

  initial begin
    test_reset();
    test_golden();
    test_stuck();
    test_out_of_range();
    test_reset_mid_run();
    test_go_held();
`ifdef FSM_CHECKER_LFSR_EN
    test_lfsr();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
